// File: rtl/exmem_pkg.sv
// Shared definitions for the execute/memory pipeline stage: FSM encoding and watchdog sizing.
package exmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } exmem_state_t;

  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] EXMEM_TIMEOUT = 8'd255;

endpackage

// File: rtl/exmem_watchdog.sv
// WAIT-cycle watchdog; only instantiated when EXMEM_TIMEOUT_EN is defined.
module exmem_watchdog
  import exmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  // expired fires during the EXMEM_TIMEOUT-th consecutive enabled cycle
  assign expired = enable && (count == EXMEM_TIMEOUT - TIMER_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/exmem_stage.sv
// Execute->memory pipeline stage: issues one memory access per load/store and hands results to writeback.
// Optional WAIT watchdog enabled by defining EXMEM_TIMEOUT_EN.
module exmem_stage
  import exmem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic [15:0]  ex_alu_out,
  input  logic [15:0]  ex_wr_data,
  input  logic         ex_mem_read,
  input  logic         ex_mem_write,
  input  logic         ex_halt,
  input  logic [15:0]  mem_rd_data,
  input  logic         mem_done,
  output logic         stall,
  output logic         mem_en,
  output logic         mem_wr,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_wdata,
  output logic [15:0]  data_exmem,
  output logic         wb_valid,
  output logic [15:0]  wb_alu_out,
  output logic [15:0]  wb_mem_data,
  output logic         wb_halt,
  output logic         err,
  output exmem_state_t dbg_state
);

  // Handshake: upstream holds its bundle stable while stall is high; a bundle with
  // ex_valid=1 is consumed at any rising edge where stall is low and no halt is pending.

  exmem_state_t state;
  logic halted;
  logic lat_write;
  logic accept;
  logic is_mem;
  logic bad_mem;
  logic timeout;

  assign is_mem    = ex_mem_read | ex_mem_write;
  assign bad_mem   = is_mem & (ex_alu_out[0] | (ex_mem_read & ex_mem_write));
  assign stall     = (state == ST_REQ) | ((state == ST_WAIT) & !mem_done);
  assign accept    = ex_valid & !halted & ((state == ST_IDLE) | ((state == ST_WAIT) & mem_done));
  assign dbg_state = state;

`ifdef EXMEM_TIMEOUT_EN
  exmem_watchdog u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (state == ST_WAIT),
    .clear   (state != ST_WAIT),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      halted      <= 1'b0;
      lat_write   <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      data_exmem  <= '0;
      wb_valid    <= 1'b0;
      wb_alu_out  <= '0;
      wb_mem_data <= '0;
      wb_halt     <= 1'b0;
      err         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_en   <= 1'b0;
      mem_wr   <= 1'b0;

      case (state)
        ST_REQ: state <= ST_WAIT;
        ST_WAIT: begin
          if (mem_done) begin
            if (!lat_write) wb_mem_data <= mem_rd_data;
            wb_alu_out <= mem_addr;
            wb_valid   <= 1'b1;
            state      <= ST_IDLE;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: ;
      endcase

      // A non-memory op accepted on the completion edge shares that writeback pulse.
      if (accept) begin
        data_exmem <= ex_alu_out;
        if (ex_halt) begin
          halted  <= 1'b1;
          wb_halt <= 1'b1;
        end
        if (bad_mem) begin
          err <= 1'b1;
        end else if (is_mem) begin
          state     <= ST_REQ;
          mem_en    <= 1'b1;
          mem_wr    <= ex_mem_write;
          lat_write <= ex_mem_write;
          mem_addr  <= ex_alu_out;
          mem_wdata <= ex_wr_data;
        end else begin
          wb_alu_out <= ex_alu_out;
          wb_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed scenarios plus randomized ALU/load/store traffic
// against a transaction-level memory model.
module tb_exmem_stage;
  import exmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ex_valid;
  logic [15:0] ex_alu_out;
  logic [15:0] ex_wr_data;
  logic ex_mem_read;
  logic ex_mem_write;
  logic ex_halt;
  logic [15:0] mem_rd_data;
  logic mem_done;
  logic stall;
  logic mem_en;
  logic mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] data_exmem;
  logic wb_valid;
  logic [15:0] wb_alu_out;
  logic [15:0] wb_mem_data;
  logic wb_halt;
  logic err;
  exmem_state_t dbg_state;

  int total = 0;
  int bad = 0;
  logic [15:0] last_load;
  logic [15:0] ref_mem [0:127];

  always #5 clk = ~clk;

  exmem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_alu_out  (ex_alu_out),
    .ex_wr_data  (ex_wr_data),
    .ex_mem_read (ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_halt     (ex_halt),
    .mem_rd_data (mem_rd_data),
    .mem_done    (mem_done),
    .stall       (stall),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .data_exmem  (data_exmem),
    .wb_valid    (wb_valid),
    .wb_alu_out  (wb_alu_out),
    .wb_mem_data (wb_mem_data),
    .wb_halt     (wb_halt),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_alu_out = '0; ex_wr_data = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_halt = 1'b0;
    mem_done = 1'b0; mem_rd_data = '0;
  endtask

  task automatic drive_bundle(input logic [15:0] a, input logic [15:0] w,
                              input logic rd, input logic wr, input logic h);
    ex_valid = 1'b1; ex_alu_out = a; ex_wr_data = w;
    ex_mem_read = rd; ex_mem_write = wr; ex_halt = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    step();
    rst = 1'b0;
    last_load = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    step(); step();
    total++;
    if ({stall, mem_en, mem_wr, mem_addr, mem_wdata, data_exmem, wb_valid,
         wb_alu_out, wb_mem_data, wb_halt, err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs err=%b wb_valid=%b mem_en=%b want all 0", err, wb_valid, mem_en);
    end
    total++;
    if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    last_load = '0;
  endtask

  task automatic test_alu();
    drive_bundle(16'h1234, 16'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive_idle();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
    total++; if (wb_alu_out !== 16'h1234) begin bad++; $display("FAIL alu_wb_alu_out: got %h want 1234", wb_alu_out); end
    total++; if (data_exmem !== 16'h1234) begin bad++; $display("FAIL alu_data_exmem: got %h want 1234", data_exmem); end
    total++; if (stall !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL alu_stall_en: got stall=%b mem_en=%b want 0/0", stall, mem_en); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_wb_pulse: got %b want 0", wb_valid); end
    total++; if (data_exmem !== 16'h1234) begin bad++; $display("FAIL alu_hold: got %h want 1234", data_exmem); end
  endtask

  task automatic test_load();
    int en_count;
    drive_bundle(16'h0040, 16'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    en_count = (mem_en === 1'b1) ? 1 : 0;
    total++; if (mem_addr !== 16'h0040 || mem_wr !== 1'b0) begin bad++; $display("FAIL load_req: got addr=%h wr=%b want 0040/0", mem_addr, mem_wr); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall_req: got %b want 1", stall); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_en === 1'b1) en_count++;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall_wait: got %b want 1 (cycle %0d)", stall, i); end
    end
    mem_done = 1'b1; mem_rd_data = 16'hBEEF;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_stall_done: got %b want 0", stall); end
    step();
    mem_done = 1'b0; mem_rd_data = '0;
    if (mem_en === 1'b1) en_count++;
    total++; if (wb_valid !== 1'b1 || wb_mem_data !== 16'hBEEF) begin bad++; $display("FAIL load_wb: got valid=%b data=%h want 1/beef", wb_valid, wb_mem_data); end
    last_load = 16'hBEEF;
    step();
    if (mem_en === 1'b1) en_count++;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL load_wb_single: got %b want 0", wb_valid); end
    total++; if (en_count != 1) begin bad++; $display("FAIL load_en_pulses: got %0d want 1", en_count); end
  endtask

  task automatic test_store();
    drive_bundle(16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0);
    step();
    drive_idle();
    total++; if (mem_en !== 1'b1 || mem_wr !== 1'b1) begin bad++; $display("FAIL store_req: got en=%b wr=%b want 1/1", mem_en, mem_wr); end
    total++; if (mem_wdata !== 16'hA5A5 || mem_addr !== 16'h0010) begin bad++; $display("FAIL store_data: got %h@%h want a5a5@0010", mem_wdata, mem_addr); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL store_early_wb: got %b want 0", wb_valid); end
    mem_done = 1'b1; mem_rd_data = 16'h1111;
    step();
    drive_idle();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL store_wb: got %b want 1", wb_valid); end
    total++; if (wb_mem_data !== last_load) begin bad++; $display("FAIL store_hold_mem_data: got %h want %h", wb_mem_data, last_load); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    vals[0] = 16'h0101; vals[1] = 16'h0202; vals[2] = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive_bundle(vals[i], 16'h0, 1'b0, 1'b0, 1'b0);
      step();
      total++;
      if (wb_valid !== 1'b1 || wb_alu_out !== vals[i]) begin
        bad++; $display("FAIL b2b_alu: got valid=%b out=%h want 1/%h", wb_valid, wb_alu_out, vals[i]);
      end
    end
    drive_bundle(16'h0020, 16'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    // next bundle presented in the done cycle must be consumed on that edge
    drive_bundle(16'h0030, 16'h7777, 1'b0, 1'b1, 1'b0);
    mem_done = 1'b1; mem_rd_data = 16'h0F0F;
    step();
    drive_idle();
    last_load = 16'h0F0F;
    total++; if (wb_valid !== 1'b1 || wb_mem_data !== 16'h0F0F || wb_alu_out !== 16'h0020) begin
      bad++; $display("FAIL b2b_load_wb: got %b/%h/%h want 1/0f0f/0020", wb_valid, wb_mem_data, wb_alu_out); end
    total++; if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0030 || mem_wdata !== 16'h7777) begin
      bad++; $display("FAIL b2b_store_req: got %b/%b/%h/%h want 1/1/0030/7777", mem_en, mem_wr, mem_addr, mem_wdata); end
    step();
    mem_done = 1'b1; mem_rd_data = 16'h2222;
    step();
    drive_idle();
    total++; if (wb_valid !== 1'b1 || wb_alu_out !== 16'h0030 || wb_mem_data !== 16'h0F0F) begin
      bad++; $display("FAIL b2b_store_wb: got %b/%h/%h want 1/0030/0f0f", wb_valid, wb_alu_out, wb_mem_data); end
    step();
  endtask

  task automatic test_random();
    int kind;
    int d;
    logic [15:0] addr;
    logic [15:0] val;
    logic [6:0] idx;
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'($urandom);
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      val  = 16'($urandom);
      idx  = 7'($urandom_range(0, 127));
      addr = {8'd0, idx, 1'b0};
      if (kind == 0) begin
        drive_bundle(val, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive_idle();
        total++;
        if (wb_valid !== 1'b1 || wb_alu_out !== val || data_exmem !== val || wb_mem_data !== last_load) begin
          bad++; $display("FAIL rand_alu: got %b/%h/%h/%h want 1/%h/%h/%h", wb_valid, wb_alu_out, data_exmem, wb_mem_data, val, val, last_load);
        end
      end else begin
        drive_bundle(addr, val, kind == 1, kind == 2, 1'b0);
        step();
        drive_idle();
        total++;
        if (mem_en !== 1'b1 || mem_addr !== addr || mem_wr !== (kind == 2) || (kind == 2 && mem_wdata !== val)) begin
          bad++; $display("FAIL rand_req: got en=%b addr=%h wr=%b wd=%h want 1/%h/%b/%h", mem_en, mem_addr, mem_wr, mem_wdata, addr, kind == 2, val);
        end
        d = $urandom_range(1, 5);
        repeat (d) step();
        mem_done = 1'b1;
        mem_rd_data = (kind == 1) ? ref_mem[idx] : 16'($urandom);
        step();
        drive_idle();
        if (kind == 2) ref_mem[idx] = val;
        else last_load = ref_mem[idx];
        total++;
        if (wb_valid !== 1'b1 || wb_mem_data !== last_load || wb_alu_out !== addr) begin
          bad++; $display("FAIL rand_wb: got %b/%h/%h want 1/%h/%h", wb_valid, wb_mem_data, wb_alu_out, last_load, addr);
        end
      end
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_unaligned();
    int en_count;
    drive_bundle(16'h0041, 16'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    en_count = (mem_en === 1'b1) ? 1 : 0;
    total++; if (err !== 1'b1 || wb_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL unaligned_err: got err=%b wb=%b st=%0d want 1/0/0", err, wb_valid, dbg_state); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_en === 1'b1) en_count++;
    end
    total++; if (en_count != 0) begin bad++; $display("FAIL unaligned_no_access: got %0d pulses want 0", en_count); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL unaligned_sticky: got %b want 1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", err); end
  endtask

  task automatic test_both_ops();
    drive_bundle(16'h0050, 16'h1234, 1'b1, 1'b1, 1'b0);
    step();
    drive_idle();
    total++; if (err !== 1'b1 || mem_en !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL both_ops: got err=%b en=%b wb=%b stall=%b want 1/0/0/0", err, mem_en, wb_valid, stall); end
    do_reset();
  endtask

  task automatic test_halt();
    drive_bundle(16'h00AA, 16'h0, 1'b0, 1'b0, 1'b1);
    step();
    drive_bundle(16'h5555, 16'h0, 1'b0, 1'b0, 1'b0);
    total++; if (wb_halt !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", wb_halt); end
    step();
    total++; if (wb_valid !== 1'b0 || data_exmem !== 16'h00AA) begin
      bad++; $display("FAIL halt_ignores: got wb=%b data=%h want 0/00aa", wb_valid, data_exmem); end
    drive_bundle(16'h0040, 16'h0, 1'b1, 1'b0, 1'b0);
    step(); step();
    drive_idle();
    total++; if (wb_halt !== 1'b1 || mem_en !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL halt_sticky: got halt=%b en=%b st=%0d want 1/0/0", wb_halt, mem_en, dbg_state); end
    do_reset();
    total++; if (wb_halt !== 1'b0) begin bad++; $display("FAIL halt_reset: got %b want 0", wb_halt); end
  endtask

  task automatic test_reset_in_wait();
    drive_bundle(16'h0060, 16'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (dbg_state !== ST_IDLE || mem_en !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL rstwait_state: got st=%0d en=%b stall=%b want 0/0/0", dbg_state, mem_en, stall); end
    mem_done = 1'b1; mem_rd_data = 16'h9999;
    step();
    drive_idle();
    total++; if (wb_valid !== 1'b0 || wb_mem_data !== 16'h0 || mem_en !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL rstwait_late_done: got wb=%b data=%h en=%b st=%0d want 0/0000/0/0", wb_valid, wb_mem_data, mem_en, dbg_state); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstwait_no_wb: got %b want 0", wb_valid); end
    last_load = '0;
  endtask

  task automatic test_timeout();
    drive_bundle(16'h0070, 16'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
`ifdef EXMEM_TIMEOUT_EN
    repeat (254) step();
    total++; if (stall !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL timeout_early: got stall=%b err=%b want 1/0", stall, err); end
    step();
    total++; if (stall !== 1'b0 || err !== 1'b1 || wb_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL timeout_fire: got stall=%b err=%b wb=%b st=%0d want 0/1/0/0", stall, err, wb_valid, dbg_state); end
`else
    repeat (300) step();
    total++; if (stall !== 1'b1 || err !== 1'b0 || dbg_state !== ST_WAIT) begin
      bad++; $display("FAIL no_timeout: got stall=%b err=%b st=%0d want 1/0/2", stall, err, dbg_state); end
`endif
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    last_load = '0;
    drive_idle();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_unaligned();
    test_both_ops();
    test_halt();
    test_reset_in_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
